// File: rtl/line_renderer_if.sv
// Line command and pixel-write bundle between the animation stage, line_renderer and the frame buffer.
// The master side issues commands and observes status; the slave side is the renderer.
interface line_renderer_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
);
  logic               start;
  logic [X_WIDTH-1:0] x0;
  logic [X_WIDTH-1:0] x1;
  logic [Y_WIDTH-1:0] y0;
  logic [Y_WIDTH-1:0] y1;
  logic               color_in;
  logic               busy;
  logic               plot;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               pixel_color;
  logic               done;

  modport master (
    output start, x0, y0, x1, y1, color_in,
    input  busy, plot, x, y, pixel_color, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, color_in,
    output busy, plot, x, y, pixel_color, done
  );
endinterface

// File: rtl/line_renderer.sv
// Bresenham line rasteriser: one pixel per clock from (x0,y0) to (x1,y1), start/busy/done handshake.
// Optional macro LINE_CLIP_EN suppresses plot strobes for points outside MAX_X x MAX_Y.
//
//   state   | meaning
//   IDLE    | waiting for start, endpoints and colour latched on acceptance
//   SETUP   | derive dx/dy/sx/sy/err, load current point with (x0,y0)
//   DRAW    | present current point, step towards (x1,y1)
//   DONE    | one-cycle done pulse, back to IDLE
module line_renderer #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9,
  parameter int MAX_X   = 640,
  parameter int MAX_Y   = 480
) (
  input logic            clk,
  input logic            reset,
  line_renderer_if.slave bus
);
  localparam int DW = X_WIDTH + 2;
  localparam int EW = X_WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [X_WIDTH-1:0] X_ONE = 1;
  localparam logic [Y_WIDTH-1:0] Y_ONE = 1;
  localparam logic [X_WIDTH:0]   MAX_X_W = MAX_X[X_WIDTH:0];
  localparam logic [Y_WIDTH:0]   MAX_Y_W = MAX_Y[Y_WIDTH:0];

  logic [1:0]          state_q, state_d;
  logic [X_WIDTH-1:0]  x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_WIDTH-1:0]  y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic                color_q, color_d;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                sx_q, sx_d, sy_q, sy_d;

  logic signed [DW-1:0] x0_s, x1_s, y0_s, y1_s, adx, ady;
  logic signed [EW-1:0] e2, dx_e, dy_e;
  logic                 step_x, step_y, at_end, draw, in_range;

  assign x0_s = signed'(DW'(x0_q));
  assign x1_s = signed'(DW'(x1_q));
  assign y0_s = signed'(DW'(y0_q));
  assign y1_s = signed'(DW'(y1_q));
  assign adx  = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
  assign ady  = (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);

  // e2 gets one extra bit so doubling err can never wrap
  assign e2     = signed'({err_q, 1'b0});
  assign dx_e   = EW'(dx_q);
  assign dy_e   = EW'(dy_q);
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign at_end = (x_q == x1_q) && (y_q == y1_q);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          x1_d    = bus.x1;
          y0_d    = bus.y0;
          y1_d    = bus.y1;
          color_d = bus.color_in;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d    = adx;
        dy_d    = -ady;
        sx_d    = (x0_q < x1_q);
        sy_d    = (y0_q < y1_q);
        err_d   = adx - ady;
        x_d     = x0_q;
        y_d     = y0_q;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          if (step_x) x_d = sx_q ? (x_q + X_ONE) : (x_q - X_ONE);
          if (step_y) y_d = sy_q ? (y_q + Y_ONE) : (y_q - Y_ONE);
          err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign draw     = (state_q == S_DRAW);
  assign in_range = ({1'b0, x_q} < MAX_X_W) && ({1'b0, y_q} < MAX_Y_W);

`ifdef LINE_CLIP_EN
  assign bus.plot = draw && in_range;
`else
  // off-screen points are still strobed; the frame buffer must drop them
  logic unused_in_range;
  assign unused_in_range = in_range;
  assign bus.plot        = draw;
`endif

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.pixel_color = draw && color_q;
endmodule

// File: tb/tb_line_renderer.sv
// Scoreboard bench for line_renderer: directed lines push expected pixels/done with their cycle numbers,
// a negedge monitor pops and compares whenever plot or done is presented.
module tb_line_renderer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    bit is_done;
    int cyc;
    int x;
    int y;
    bit col;
  } exp_t;

  exp_t sb[$];

  line_renderer_if #(.X_WIDTH(10), .Y_WIDTH(9)) bus ();

  line_renderer #(.X_WIDTH(10), .Y_WIDTH(9), .MAX_X(640), .MAX_Y(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_plot(input int c, input int px, input int py, input bit col);
    exp_t e;
    e.is_done = 1'b0; e.cyc = c; e.x = px; e.y = py; e.col = col;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.cyc = c; e.x = 0; e.y = 0; e.col = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  // Drives one start pulse; afterwards the coordinate inputs are scrambled to prove they were latched.
  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit col, output int c0);
    bus.start    = 1'b1;
    bus.x0       = 10'(ax0);
    bus.y0       = 9'(ay0);
    bus.x1       = 10'(ax1);
    bus.y1       = 9'(ay1);
    bus.color_in = col;
    c0 = cyc;
    @(negedge clk);
    #1;
    bus.start    = 1'b0;
    bus.x0       = 10'd777;
    bus.y0       = 9'd333;
    bus.x1       = 10'd111;
    bus.y1       = 9'd222;
    bus.color_in = ~col;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.plot || bus.done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got plot=%0b done=%0b x=%0d y=%0d expected nothing (cycle %0d)",
                   bus.plot, bus.done, bus.x, bus.y, cyc);
        end else begin
          e = sb.pop_front();
          check("out_kind_done", int'(bus.done), int'(e.is_done));
          check("out_cycle", cyc, e.cyc);
          if (e.is_done) begin
            check("done_no_plot", int'(bus.plot), 0);
            check("done_pixel_color", int'(bus.pixel_color), 0);
          end else begin
            check("plot_x", int'(bus.x), e.x);
            check("plot_y", int'(bus.y), e.y);
            check("plot_color", int'(bus.pixel_color), int'(e.col));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int c;
    int dgx[5] = '{0, 1, 2, 3, 4};
    int dgy[5] = '{0, 1, 1, 2, 2};
    int stx[6] = '{0, 0, 1, 1, 2, 2};
    int sty[6] = '{0, 1, 2, 3, 4, 5};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x0       = '0;
    bus.y0       = '0;
    bus.x1       = '0;
    bus.y1       = '0;
    bus.color_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_pixel_color", int'(bus.pixel_color), 0);
    #1 reset = 1'b0;
    wait_cycle(cyc + 1);

    // vertical, upward stepping
    start_line(5, 479, 5, 470, 1'b1, c);
    for (int k = 0; k < 10; k++) push_plot(c + 2 + k, 5, 479 - k, 1'b1);
    push_done(c + 12);
    wait_cycle(c + 13);

    // horizontal reversed, colour 0, busy window
    start_line(20, 100, 15, 100, 1'b0, c);
    for (int k = 0; k < 6; k++) push_plot(c + 2 + k, 20 - k, 100, 1'b0);
    push_done(c + 8);
    for (int k = 1; k <= 9; k++) begin
      wait_cycle(c + k);
      check("busy_window", int'(bus.busy), (k <= 8) ? 1 : 0);
    end

    // shallow diagonal
    start_line(0, 0, 4, 2, 1'b1, c);
    for (int k = 0; k < 5; k++) push_plot(c + 2 + k, dgx[k], dgy[k], 1'b1);
    push_done(c + 7);
    wait_cycle(c + 8);

    // single point on the off-screen baseline row
    start_line(3, 480, 3, 480, 1'b1, c);
`ifndef LINE_CLIP_EN
    push_plot(c + 2, 3, 480, 1'b1);
`endif
    push_done(c + 3);
    wait_cycle(c + 4);

    // steep line with a start pulse during DRAW that must be ignored
    start_line(0, 0, 2, 5, 1'b1, c);
    for (int k = 0; k < 6; k++) push_plot(c + 2 + k, stx[k], sty[k], 1'b1);
    push_done(c + 8);
    wait_cycle(c + 3);
    bus.start = 1'b1;
    bus.x0    = 10'd100;
    bus.y0    = 9'd100;
    bus.x1    = 10'd200;
    bus.y1    = 9'd200;
    wait_cycle(c + 4);
    bus.start = 1'b0;

    // back-to-back: start in the first IDLE cycle after done
    wait_cycle(c + 9);
    start_line(3, 3, 0, 0, 1'b0, c);
    for (int k = 0; k < 4; k++) push_plot(c + 2 + k, 3 - k, 3 - k, 1'b0);
    push_done(c + 6);
    wait_cycle(c + 7);

    // reset during the 4th plot
    start_line(0, 0, 0, 9, 1'b1, c);
    for (int k = 0; k < 4; k++) push_plot(c + 2 + k, 0, k, 1'b1);
    wait_cycle(c + 5);
    reset = 1'b1;
    check("pre_reset_drain", sb.size(), 0);
    sb.delete();
    wait_cycle(c + 6);
    check("abort_plot", int'(bus.plot), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_x", int'(bus.x), 0);
    check("abort_y", int'(bus.y), 0);
    reset = 1'b0;
    wait_cycle(c + 15);

    start_line(1, 0, 1, 9, 1'b1, c);
    for (int k = 0; k < 10; k++) push_plot(c + 2 + k, 1, k, 1'b1);
    push_done(c + 12);
    wait_cycle(c + 14);

    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
